// File: rtl/ssd_scan_driver_if.sv
// Bus bundle for the multiplexed seven-segment scan driver.
// The master side supplies display data and controls; the slave side (the driver)
// returns segment lines, digit enables and scan status.
interface ssd_scan_driver_if #(
   parameter int NUM_DIGITS = 4
);
   localparam int IDX_W = $clog2(NUM_DIGITS);

   logic                    en;
   logic                    load;
   logic [4*NUM_DIGITS-1:0] digits;
   logic [NUM_DIGITS-1:0]   dp_in;
   logic [NUM_DIGITS-1:0]   blank_in;
   logic                    lz_en;

   logic                    a, b, c, d, e, f, g;
   logic                    dp;
   logic [NUM_DIGITS-1:0]   an;
   logic [IDX_W-1:0]        digit_idx;
   logic                    frame_start;

   modport master (
      output en, load, digits, dp_in, blank_in, lz_en,
      input  a, b, c, d, e, f, g, dp, an, digit_idx, frame_start
   );

   modport slave (
      input  en, load, digits, dp_in, blank_in, lz_en,
      output a, b, c, d, e, f, g, dp, an, digit_idx, frame_start
   );
endinterface

// File: rtl/ssd_scan_driver.sv
// Time-multiplexed multi-digit seven-segment driver with frame-synchronous
// double-buffered loading, per-digit blanking and leading-zero suppression.
module ssd_scan_driver #(
   parameter int NUM_DIGITS     = 4,
   parameter int REFRESH_DIV    = 1000,
   parameter int SEG_ACTIVE_LOW = 0,
   parameter int AN_ACTIVE_LOW  = 0
) (
   input logic               clk,
   input logic               rst,
   ssd_scan_driver_if.slave  bus
);
   localparam int IDX_W = $clog2(NUM_DIGITS);
   localparam int PS_W  = $clog2(REFRESH_DIV);
   localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(REFRESH_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
   localparam logic SEG_POL = (SEG_ACTIVE_LOW != 0);
   localparam logic AN_POL  = (AN_ACTIVE_LOW != 0);

   logic [PS_W-1:0]         ps_q;
   logic [IDX_W-1:0]        idx_q;
   logic                    fs_q;

   logic [4*NUM_DIGITS-1:0] pd_digits, sh_digits;
   logic [NUM_DIGITS-1:0]   pd_dp, sh_dp;
   logic [NUM_DIGITS-1:0]   pd_blank, sh_blank;
   logic                    pd_valid;

   logic [6:0]              seg_q;
   logic                    dp_q;
   logic [NUM_DIGITS-1:0]   an_q;

   logic                    tick, wrap;
   logic [3:0]              nib;
   logic                    nz_above, suppress;
   logic [6:0]              seg_lit;
   logic                    dp_lit;
   logic [NUM_DIGITS-1:0]   an_lit;

   assign tick = bus.en && (ps_q == PS_LAST);
   assign wrap = tick && (idx_q == IDX_LAST);

   // Prescaler and digit scan counter; both freeze while disabled.
   always_ff @(posedge clk) begin
      if (rst) begin
         ps_q  <= '0;
         idx_q <= '0;
         fs_q  <= 1'b0;
      end else begin
         if (bus.en) ps_q <= tick ? '0 : ps_q + 1'b1;
         if (tick)   idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
         fs_q <= wrap;
      end
   end

   // Pending/shadow buffers: shadow only changes on the frame wrap so a frame
   // never mixes two loads; a load landing on the wrap bypasses pending.
   always_ff @(posedge clk) begin
      if (rst) begin
         pd_digits <= '0;
         pd_dp     <= '0;
         pd_blank  <= '0;
         pd_valid  <= 1'b0;
         sh_digits <= '0;
         sh_dp     <= '0;
         sh_blank  <= '0;
      end else if (wrap && bus.load) begin
         sh_digits <= bus.digits;
         sh_dp     <= bus.dp_in;
         sh_blank  <= bus.blank_in;
         pd_valid  <= 1'b0;
      end else begin
         if (wrap && pd_valid) begin
            sh_digits <= pd_digits;
            sh_dp     <= pd_dp;
            sh_blank  <= pd_blank;
            pd_valid  <= 1'b0;
         end
         if (bus.load) begin
            pd_digits <= bus.digits;
            pd_dp     <= bus.dp_in;
            pd_blank  <= bus.blank_in;
            pd_valid  <= 1'b1;
         end
      end
   end

   // Logical (active-high) segment/enable values for the digit being scanned.
   always_comb begin
      nib      = sh_digits[{idx_q, 2'b00} +: 4];
      nz_above = 1'b0;
      for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
         if ((j >= 32'(idx_q)) && (sh_digits[j*4 +: 4] != 4'h0)) nz_above = 1'b1;
      end
      suppress = bus.lz_en && (idx_q != '0) && !nz_above;

      seg_lit = '0;
      case (nib)
         4'h0: seg_lit = 7'b1111110;
         4'h1: seg_lit = 7'b0110000;
         4'h2: seg_lit = 7'b1101101;
         4'h3: seg_lit = 7'b1111001;
         4'h4: seg_lit = 7'b0110011;
         4'h5: seg_lit = 7'b1011011;
         4'h6: seg_lit = 7'b1011111;
         4'h7: seg_lit = 7'b1110000;
         4'h8: seg_lit = 7'b1111111;
         4'h9: seg_lit = 7'b1111011;
         4'hA: seg_lit = 7'b1110111;
         4'hB: seg_lit = 7'b0011111;
         4'hC: seg_lit = 7'b1001110;
         4'hD: seg_lit = 7'b0111101;
         4'hE: seg_lit = 7'b1001111;
         4'hF: seg_lit = 7'b1000111;
      endcase
      dp_lit = sh_dp[idx_q];

      if (sh_blank[idx_q]) begin
         seg_lit = '0;
         dp_lit  = 1'b0;
      end else if (suppress) begin
         seg_lit = '0;
      end

      an_lit        = '0;
      an_lit[idx_q] = 1'b1;

      if (!bus.en) begin
         seg_lit = '0;
         dp_lit  = 1'b0;
         an_lit  = '0;
      end
   end

   // Output register with polarity applied last; enables and segments move together.
   always_ff @(posedge clk) begin
      if (rst) begin
         seg_q <= {7{SEG_POL}};
         dp_q  <= SEG_POL;
         an_q  <= {NUM_DIGITS{AN_POL}};
      end else begin
         seg_q <= seg_lit ^ {7{SEG_POL}};
         dp_q  <= dp_lit ^ SEG_POL;
         an_q  <= an_lit ^ {NUM_DIGITS{AN_POL}};
      end
   end

   assign {bus.a, bus.b, bus.c, bus.d, bus.e, bus.f, bus.g} = seg_q;
   assign bus.dp          = dp_q;
   assign bus.an          = an_q;
   assign bus.digit_idx   = idx_q;
   assign bus.frame_start = fs_q;
endmodule

// File: tb/tb_ssd_scan_driver.sv
// Directed bench for ssd_scan_driver: two instances (active-high and active-low
// polarity) driven identically, compared against hand-computed vectors.
module tb_ssd_scan_driver;
   localparam int ND = 4;
   localparam int RD = 4;

   localparam logic [6:0] S0   = 7'b1111110;
   localparam logic [6:0] S1   = 7'b0110000;
   localparam logic [6:0] S2   = 7'b1101101;
   localparam logic [6:0] S3   = 7'b1111001;
   localparam logic [6:0] S5   = 7'b1011011;
   localparam logic [6:0] S8   = 7'b1111111;
   localparam logic [6:0] SA   = 7'b1110111;
   localparam logic [6:0] SF   = 7'b1000111;
   localparam logic [6:0] SOFF = 7'b0000000;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ssd_scan_driver_if #(.NUM_DIGITS(ND)) bus0 ();
   ssd_scan_driver_if #(.NUM_DIGITS(ND)) bus1 ();

   ssd_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(0))
      dut0 (.clk(clk), .rst(rst), .bus(bus0));
   ssd_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1))
      dut1 (.clk(clk), .rst(rst), .bus(bus1));

   typedef struct {
      int unsigned at;
      logic        en, load, lz;
      logic [15:0] digits;
      logic [3:0]  dp_in, blank_in;
      logic [6:0]  seg;
      logic        dp;
      logic [3:0]  an;
      logic [1:0]  idx;
      logic        fs;
   } vec_t;

   vec_t        vecs[$];
   int unsigned n;
   int unsigned applied;
   int unsigned miscompares;

   function automatic vec_t v(int unsigned at, logic en, logic load, logic lz,
                              logic [15:0] digits, logic [3:0] dp_in, logic [3:0] blank_in,
                              logic [6:0] seg, logic dp, logic [3:0] an, logic [1:0] idx, logic fs);
      vec_t r;
      r.at = at; r.en = en; r.load = load; r.lz = lz;
      r.digits = digits; r.dp_in = dp_in; r.blank_in = blank_in;
      r.seg = seg; r.dp = dp; r.an = an; r.idx = idx; r.fs = fs;
      return r;
   endfunction

   task automatic drive(input logic en, input logic load, input logic lz,
                        input logic [15:0] digits, input logic [3:0] dp_in, input logic [3:0] blank_in);
      bus0.en = en; bus0.load = load; bus0.lz_en = lz;
      bus0.digits = digits; bus0.dp_in = dp_in; bus0.blank_in = blank_in;
      bus1.en = en; bus1.load = load; bus1.lz_en = lz;
      bus1.digits = digits; bus1.dp_in = dp_in; bus1.blank_in = blank_in;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      n++;
   endtask

   task automatic check(input string name, input logic [6:0] seg, input logic dp,
                        input logic [3:0] an, input logic [1:0] idx, input logic fs);
      logic [14:0] act0, exp0, act1, exp1;
      act0 = {bus0.a, bus0.b, bus0.c, bus0.d, bus0.e, bus0.f, bus0.g,
              bus0.dp, bus0.an, bus0.digit_idx, bus0.frame_start};
      exp0 = {seg, dp, an, idx, fs};
      act1 = {bus1.a, bus1.b, bus1.c, bus1.d, bus1.e, bus1.f, bus1.g,
              bus1.dp, bus1.an, bus1.digit_idx, bus1.frame_start};
      exp1 = {~seg, ~dp, ~an, idx, fs};
      applied++;
      if (act0 !== exp0) begin
         miscompares++;
         $display("FAIL %s active-high n=%0d got seg.dp.an.idx.fs=%b want %b", name, n, act0, exp0);
      end
      applied++;
      if (act1 !== exp1) begin
         miscompares++;
         $display("FAIL %s active-low n=%0d got seg.dp.an.idx.fs=%b want %b", name, n, act1, exp1);
      end
   endtask

   initial begin
      n = 0; applied = 0; miscompares = 0;

      // scan basics with cleared shadow
      vecs.push_back(v(  1, 1,0,0, 16'h0000, 4'b0000, 4'b0000, S0,  0, 4'b0001, 2'd0, 0));
      vecs.push_back(v(  4, 1,0,0, 16'h0000, 4'b0000, 4'b0000, S0,  0, 4'b0001, 2'd1, 0));
      vecs.push_back(v(  5, 1,0,0, 16'h0000, 4'b0000, 4'b0000, S0,  0, 4'b0010, 2'd1, 0));
      vecs.push_back(v(  9, 1,0,0, 16'h0000, 4'b0000, 4'b0000, S0,  0, 4'b0100, 2'd2, 0));
      vecs.push_back(v( 13, 1,0,0, 16'h0000, 4'b0000, 4'b0000, S0,  0, 4'b1000, 2'd3, 0));
      vecs.push_back(v( 16, 1,0,0, 16'h0000, 4'b0000, 4'b0000, S0,  0, 4'b1000, 2'd0, 1));
      vecs.push_back(v( 17, 1,0,0, 16'h0000, 4'b0000, 4'b0000, S0,  0, 4'b0001, 2'd0, 0));
      // mid-frame load of 1F3A, visible only after the next wrap
      vecs.push_back(v( 18, 1,1,0, 16'h1F3A, 4'b0100, 4'b0000, S0,  0, 4'b0001, 2'd0, 0));
      vecs.push_back(v( 21, 1,0,0, 16'h1F3A, 4'b0100, 4'b0000, S0,  0, 4'b0010, 2'd1, 0));
      vecs.push_back(v( 32, 1,0,0, 16'h1F3A, 4'b0100, 4'b0000, S0,  0, 4'b1000, 2'd0, 1));
      vecs.push_back(v( 33, 1,0,0, 16'h1F3A, 4'b0100, 4'b0000, SA,  0, 4'b0001, 2'd0, 0));
      vecs.push_back(v( 37, 1,0,0, 16'h1F3A, 4'b0100, 4'b0000, S3,  0, 4'b0010, 2'd1, 0));
      vecs.push_back(v( 41, 1,0,0, 16'h1F3A, 4'b0100, 4'b0000, SF,  1, 4'b0100, 2'd2, 0));
      vecs.push_back(v( 45, 1,0,0, 16'h1F3A, 4'b0100, 4'b0000, S1,  0, 4'b1000, 2'd3, 0));
      vecs.push_back(v( 48, 1,0,0, 16'h1F3A, 4'b0100, 4'b0000, S1,  0, 4'b1000, 2'd0, 1));
      // two loads in one frame: last wins; then a load on the wrap tick
      vecs.push_back(v( 50, 1,1,0, 16'h1111, 4'b0000, 4'b0000, SA,  0, 4'b0001, 2'd0, 0));
      vecs.push_back(v( 54, 1,1,0, 16'h2222, 4'b0000, 4'b0000, S3,  0, 4'b0010, 2'd1, 0));
      vecs.push_back(v( 55, 1,0,0, 16'h2222, 4'b0000, 4'b0000, S3,  0, 4'b0010, 2'd1, 0));
      vecs.push_back(v( 64, 1,0,0, 16'h2222, 4'b0000, 4'b0000, S1,  0, 4'b1000, 2'd0, 1));
      vecs.push_back(v( 65, 1,0,0, 16'h2222, 4'b0000, 4'b0000, S2,  0, 4'b0001, 2'd0, 0));
      vecs.push_back(v( 69, 1,0,0, 16'h2222, 4'b0000, 4'b0000, S2,  0, 4'b0010, 2'd1, 0));
      vecs.push_back(v( 79, 1,0,0, 16'h2222, 4'b0000, 4'b0000, S2,  0, 4'b1000, 2'd3, 0));
      vecs.push_back(v( 80, 1,1,0, 16'h4321, 4'b0000, 4'b0000, S2,  0, 4'b1000, 2'd0, 1));
      vecs.push_back(v( 81, 1,0,0, 16'h4321, 4'b0000, 4'b0000, S1,  0, 4'b0001, 2'd0, 0));
      // leading-zero suppression
      vecs.push_back(v( 82, 1,1,1, 16'h0050, 4'b0000, 4'b0000, S1,  0, 4'b0001, 2'd0, 0));
      vecs.push_back(v( 85, 1,0,1, 16'h0050, 4'b0000, 4'b0000, S2,  0, 4'b0010, 2'd1, 0));
      vecs.push_back(v( 97, 1,0,1, 16'h0050, 4'b0000, 4'b0000, S0,  0, 4'b0001, 2'd0, 0));
      vecs.push_back(v(101, 1,0,1, 16'h0050, 4'b0000, 4'b0000, S5,  0, 4'b0010, 2'd1, 0));
      vecs.push_back(v(105, 1,0,1, 16'h0050, 4'b0000, 4'b0000, SOFF,0, 4'b0100, 2'd2, 0));
      vecs.push_back(v(109, 1,0,1, 16'h0050, 4'b0000, 4'b0000, SOFF,0, 4'b1000, 2'd3, 0));
      vecs.push_back(v(110, 1,1,1, 16'h0000, 4'b0000, 4'b0000, SOFF,0, 4'b1000, 2'd3, 0));
      vecs.push_back(v(113, 1,0,1, 16'h0000, 4'b0000, 4'b0000, S0,  0, 4'b0001, 2'd0, 0));
      vecs.push_back(v(117, 1,0,1, 16'h0000, 4'b0000, 4'b0000, SOFF,0, 4'b0010, 2'd1, 0));
      vecs.push_back(v(121, 1,0,0, 16'h0000, 4'b0000, 4'b0000, S0,  0, 4'b0100, 2'd2, 0));
      vecs.push_back(v(125, 1,0,0, 16'h0000, 4'b0000, 4'b0000, S0,  0, 4'b1000, 2'd3, 0));
      vecs.push_back(v(126, 1,1,1, 16'h0000, 4'b1000, 4'b0000, SOFF,0, 4'b1000, 2'd3, 0));
      vecs.push_back(v(133, 1,0,1, 16'h0000, 4'b1000, 4'b0000, SOFF,0, 4'b0010, 2'd1, 0));
      vecs.push_back(v(141, 1,0,1, 16'h0000, 4'b1000, 4'b0000, SOFF,1, 4'b1000, 2'd3, 0));
      // blanking (dut1 covers the inverted polarities throughout)
      vecs.push_back(v(142, 1,1,0, 16'h8888, 4'b0010, 4'b0010, S0,  1, 4'b1000, 2'd3, 0));
      vecs.push_back(v(145, 1,0,0, 16'h8888, 4'b0010, 4'b0010, S8,  0, 4'b0001, 2'd0, 0));
      vecs.push_back(v(149, 1,0,0, 16'h8888, 4'b0010, 4'b0010, SOFF,0, 4'b0010, 2'd1, 0));
      vecs.push_back(v(153, 1,0,0, 16'h8888, 4'b0010, 4'b0010, S8,  0, 4'b0100, 2'd2, 0));

      // reset with enable high: everything inactive
      rst = 1'b1;
      drive(1'b1, 1'b0, 1'b0, 16'h0000, 4'b0000, 4'b0000);
      step(); check("reset_c1", SOFF, 0, 4'b0000, 2'd0, 0);
      step(); check("reset_c2", SOFF, 0, 4'b0000, 2'd0, 0);
      rst = 1'b0;
      n = 0;

      foreach (vecs[i]) begin
         drive(vecs[i].en, vecs[i].load, vecs[i].lz, vecs[i].digits, vecs[i].dp_in, vecs[i].blank_in);
         if (vecs[i].at <= n) begin
            applied++;
            miscompares++;
            $display("FAIL vec%0d ordering got n=%0d want n<%0d", i, n, vecs[i].at);
         end
         while (n < vecs[i].at) begin
            step();
            bus0.load = 1'b0;
            bus1.load = 1'b0;
         end
         check($sformatf("vec%0d", i), vecs[i].seg, vecs[i].dp, vecs[i].an, vecs[i].idx, vecs[i].fs);
      end

      // enable dropped mid-slot (prescaler at 1, digit 2) for 10 cycles
      drive(1'b0, 1'b0, 1'b0, 16'h8888, 4'b0010, 4'b0010);
      for (int k = 0; k < 10; k++) begin
         step();
         check($sformatf("en_off%0d", k), SOFF, 0, 4'b0000, 2'd2, 0);
      end
      // resume: three more cycles finish the digit-2 slot
      drive(1'b1, 1'b0, 1'b0, 16'h8888, 4'b0010, 4'b0010);
      step(); check("resume1", S8, 0, 4'b0100, 2'd2, 0);
      step(); check("resume2", S8, 0, 4'b0100, 2'd2, 0);
      step(); check("resume3", S8, 0, 4'b0100, 2'd3, 0);
      step(); check("resume4", S8, 0, 4'b1000, 2'd3, 0);

      // reset coincident with a load: load ignored, shadow cleared
      rst = 1'b1;
      drive(1'b1, 1'b1, 1'b0, 16'hFFFF, 4'b1111, 4'b0000);
      step(); check("rst_load", SOFF, 0, 4'b0000, 2'd0, 0);
      rst = 1'b0;
      drive(1'b1, 1'b0, 1'b0, 16'hFFFF, 4'b1111, 4'b0000);
      n = 0;
      for (int m = 1; m <= 17; m++) begin
         step();
         if (m == 1)  check("post_rst_d0",   S0, 0, 4'b0001, 2'd0, 0);
         if (m == 5)  check("post_rst_d1",   S0, 0, 4'b0010, 2'd1, 0);
         if (m == 16) check("post_rst_wrap", S0, 0, 4'b1000, 2'd0, 1);
         if (m == 17) check("post_rst_next", S0, 0, 4'b0001, 2'd0, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
      $finish;
   end
endmodule

// File: doc/ssd_scan_driver.md
Name: ssd_scan_driver

Overview:
Parametrised multi-digit, time-multiplexed seven-segment driver; successor to the single-digit 4-bit hex decoder. Holds NUM_DIGITS hex nibbles plus per-digit decimal points. Scans one digit per refresh slot, driving shared segment lines a-g/dp and one-hot digit enables. Adds frame-synchronous double-buffered loading, per-digit blanking, leading-zero suppression and selectable output polarity.

Parameters:
NUM_DIGITS, 4, digits scanned (2..8)
REFRESH_DIV, 1000, clk cycles per digit slot (>=2)
SEG_ACTIVE_LOW, 0, 1 = segment/dp lines lit when 0
AN_ACTIVE_LOW, 0, 1 = digit enables active when 0

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
en  in  1  scan enable
load  in  1  one-cycle strobe; capture digits/dp_in/blank_in
digits  in  4*NUM_DIGITS  hex nibbles, digit i = bits [4i+3:4i], digit 0 = least significant
dp_in  in  NUM_DIGITS  decimal point per digit
blank_in  in  NUM_DIGITS  1 = digit i dark
lz_en  in  1  leading-zero suppression enable
a,b,c,d,e,f,g  out  1 each  segment lines
dp  out  1  decimal point line
an  out  NUM_DIGITS  digit enables, one-hot when active
digit_idx  out  clog2(NUM_DIGITS)  digit currently being scanned
frame_start  out  1  one-cycle pulse when the scan wraps to digit 0

Behaviour:
- One clock; reset synchronous, active-high; all state updates on rising clk.
- Reset: prescaler=0, digit_idx=0, pending buffer, pending flag and shadow register cleared, frame_start=0; a-g, dp and all an at inactive level (SEG_ACTIVE_LOW/AN_ACTIVE_LOW applied). Reset overrides load and en in the same cycle.
- Prescaler: when en=1, counts 0..REFRESH_DIV-1. tick = (prescaler==REFRESH_DIV-1 and en). On tick: prescaler->0; digit_idx increments, wrapping NUM_DIGITS-1 -> 0.
- frame_start=1 for exactly the cycle after a tick that wraps digit_idx to 0; otherwise 0.
- en=0: prescaler and digit_idx hold; all an inactive; segments inactive. Scanning resumes from the held count when en returns to 1.
- Double buffer:
  - load=1 copies digits/dp_in/blank_in into the pending buffer and sets pending.
  - On a wrap tick with pending=1: pending copied to shadow, pending cleared.
  - load coincident with a wrap tick: inputs go directly to shadow, pending cleared.
  - Repeated loads within one frame: last one wins.
  - The display never mixes two loads within one frame.
- Decode (shadow nibble of digit_idx), lit segments: 0 abcdef; 1 bc; 2 abdeg; 3 abcdg; 4 bcfg; 5 acdfg; 6 acdefg; 7 abc; 8 abcdefg; 9 abcdfg; A abcefg; b cdefg; C adef; d bcdeg; E adefg; F aefg.
- Leading-zero suppression (lz_en=1): digit i (i>=1) is dark if its nibble and every nibble above it are 0. Digit 0 is never suppressed. A suppressed digit still shows its dp if dp set.
- blank=1: segments and dp off for that digit, but its an is still driven for the full slot. Brightness duty per digit is constant, regardless of blank or suppression.
- Outputs registered: a-g/dp/an reflect the digit_idx value of the previous cycle (1-cycle latency). The an change and the segment change occur on the same edge; there is no ghosting cycle.
- Polarity applied last: logical lit/active XOR the ACTIVE_LOW parameter.
- lz_en is sampled live, not double-buffered.

Test Plan:
1. NUM_DIGITS=4, REFRESH_DIV=4, rst for 2 cycles, en=1, no load -> all outputs inactive during reset. After reset, digit 0 shows "0" (a-f=1, g=0, dp=0). an sequence 0001,0010,0100,1000 with each state held 4 cycles. frame_start pulses every 16 cycles.
2. load digits=16'h1F3A, dp_in=4'b0100, mid-frame -> display unchanged until the next wrap. Then slots show A(abcefg), 3(abcdg), F(aefg)+dp, 1(bc).
3. Two loads in one frame (16'h1111, then 16'h2222), and a load coincident with a wrap tick -> only 2222 appears, starting at the next frame. The coincident load is visible in the immediately following digit-0 slot.
4. digits=16'h0050, lz_en=1 -> digits 3 and 2 dark, digit 1 shows 5, digit 0 shows 0. With digits=16'h0000, only digit 0 lit. With lz_en=0, all four digits lit.
5. blank_in=4'b0010, SEG_ACTIVE_LOW=1, AN_ACTIVE_LOW=1 -> digit 1 slot has an=1101 and all segments/dp high. Other slots are correctly inverted.
6. en deasserted mid-slot for 10 cycles, then rst asserted with load=1 -> while disabled, an all inactive and digit_idx held. Resumption finishes the remaining slot count. Reset clears the shadow, ignores the load, and returns to digit 0.
